hazard_unit_mc: RTL and testbench

Multi-cycle-aware hazard unit for the 5-stage RV32 pipeline, the successor to the single-cycle hazard block. It adds three things to M/W→E forwarding and branch flushing: a parametrised load-use bubble count for multi-cycle data memory, a start/done handshake that freezes the pipeline around a multi-cycle multiply/divide unit (MDU) in E, and an MDU watchdog. It sits beside the datapath and drives the stall, flush and forward-select lines of the F, FD, DE and EM pipeline registers.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_fwd_sel.sv | 27 ++
 rtl/hazard_unit_mc.sv | 171 +++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard unit: result-source codes,
// forward-select codes and the hazard FSM state constants.
package hazard_pkg;

  // Where the writeback value of an instruction comes from
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_IMM = 2'b10,
    RES_PC4 = 2'b11
  } result_src_t;

  // ALU operand forward select driven into the E-stage operand muxes
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_W     = 2'b01,
    FWD_M     = 2'b10,
    FWD_M_PC4 = 2'b11
  } fwd_sel_t;

  // Hazard FSM states; plain constants so older tools can consume them
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_LD_STALL = 2'd1;
  localparam state_t ST_MDU_BUSY = 2'd2;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand forward selection. The M stage holds the younger result,
// so an M match wins over a W match; x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] e_rs,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic [REG_ADDR_W-1:0] w_rd,
  input  logic                  m_we,
  input  logic                  w_we,
  input  logic [1:0]            m_src,
  output logic [1:0]            fwd_src
);

  // Pick the freshest producer of e_rs, preferring the M stage
  always_comb begin
    fwd_src = FWD_RF;
    if (m_we && (e_rs != '0) && (e_rs == m_rd)) begin
      fwd_src = (m_src == RES_PC4) ? FWD_M_PC4 : FWD_M;
    end else if (w_we && (e_rs != '0) && (e_rs == w_rd)) begin
      fwd_src = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Multi-cycle-aware hazard unit: M/W->E forwarding, branch flushing,
// multi-bubble load-use stalls and a start/done freeze around the MDU with
// a sticky watchdog flag. All outputs are forced low while reset is held.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MDU_TIMEOUT       = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_data_d_rs1,
  input  logic [REG_ADDR_W-1:0] i_data_d_rs2,
  input  logic [REG_ADDR_W-1:0] i_data_e_rs1,
  input  logic [REG_ADDR_W-1:0] i_data_e_rs2,
  input  logic [REG_ADDR_W-1:0] i_data_e_rd,
  input  logic [REG_ADDR_W-1:0] i_data_m_rd,
  input  logic [REG_ADDR_W-1:0] i_data_w_rd,
  input  logic                  i_ctrl_d_use_rs1,
  input  logic [1:0]            i_ctrl_e_mux_final_result_src,
  input  logic [1:0]            i_ctrl_m_mux_final_result_src,
  input  logic                  i_ctrl_m_en_regfile_write,
  input  logic                  i_ctrl_w_en_regfile_write,
  input  logic                  i_ctrl_e_mux_pc_src,
  input  logic                  i_ctrl_e_mdu_op,
  input  logic                  i_mdu_done,
  output logic [1:0]            o_data_mux_alu_forward_src_a,
  output logic [1:0]            o_data_mux_alu_forward_src_b,
  output logic                  o_data_f_stall,
  output logic                  o_data_fd_stall,
  output logic                  o_data_de_stall,
  output logic                  o_de_flush,
  output logic                  o_data_fd_flush,
  output logic                  o_em_flush,
  output logic                  o_mdu_start,
  output logic                  o_mdu_timeout
);

  localparam logic [2:0] LD_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] WD_LIMIT  = 8'(MDU_TIMEOUT);

  state_t     state, state_next;
  logic [2:0] ld_cnt, ld_cnt_next;
  logic [7:0] wd_cnt, wd_cnt_next;
  logic       timeout_q, timeout_next;

  logic [1:0] fwd_a, fwd_b;
  logic       load_use;
  logic       f_stall, fd_stall, de_stall;
  logic       de_flush, fd_flush, em_flush, mdu_start;

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .e_rs    (i_data_e_rs1),
    .m_rd    (i_data_m_rd),
    .w_rd    (i_data_w_rd),
    .m_we    (i_ctrl_m_en_regfile_write),
    .w_we    (i_ctrl_w_en_regfile_write),
    .m_src   (i_ctrl_m_mux_final_result_src),
    .fwd_src (fwd_a)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .e_rs    (i_data_e_rs2),
    .m_rd    (i_data_m_rd),
    .w_rd    (i_data_w_rd),
    .m_we    (i_ctrl_m_en_regfile_write),
    .w_we    (i_ctrl_w_en_regfile_write),
    .m_src   (i_ctrl_m_mux_final_result_src),
    .fwd_src (fwd_b)
  );

  assign load_use = (i_ctrl_e_mux_final_result_src == RES_MEM) &&
                    (i_data_e_rd != '0) &&
                    (((i_data_e_rd == i_data_d_rs1) && i_ctrl_d_use_rs1) ||
                     (i_data_e_rd == i_data_d_rs2));

  // Next-state, counter updates and raw stall/flush decode for each state
  always_comb begin
    state_next   = state;
    ld_cnt_next  = ld_cnt;
    wd_cnt_next  = wd_cnt;
    timeout_next = timeout_q;
    f_stall      = 1'b0;
    fd_stall     = 1'b0;
    de_stall     = 1'b0;
    de_flush     = 1'b0;
    fd_flush     = 1'b0;
    em_flush     = 1'b0;
    mdu_start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_ctrl_e_mdu_op) begin
          mdu_start   = 1'b1;
          f_stall     = 1'b1;
          fd_stall    = 1'b1;
          de_stall    = 1'b1;
          em_flush    = 1'b1;
          wd_cnt_next = 8'd0;
          state_next  = ST_MDU_BUSY;
        end else if (i_ctrl_e_mux_pc_src) begin
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (load_use) begin
          f_stall  = 1'b1;
          fd_stall = 1'b1;
          de_flush = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            ld_cnt_next = LD_RELOAD;
            state_next  = ST_LD_STALL;
          end
        end
      end
      ST_LD_STALL: begin
        f_stall  = 1'b1;
        fd_stall = 1'b1;
        de_flush = 1'b1;
        if (ld_cnt <= 3'd1) begin
          ld_cnt_next = 3'd0;
          state_next  = ST_IDLE;
        end else begin
          ld_cnt_next = ld_cnt - 3'd1;
        end
      end
      ST_MDU_BUSY: begin
        if (!i_mdu_done) begin
          f_stall     = 1'b1;
          fd_stall    = 1'b1;
          de_stall    = 1'b1;
          em_flush    = 1'b1;
          wd_cnt_next = (wd_cnt == 8'hFF) ? wd_cnt : wd_cnt + 8'd1;
          if (wd_cnt_next >= WD_LIMIT) begin
            timeout_next = 1'b1;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset aborts any stall or MDU wait
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      ld_cnt    <= 3'd0;
      wd_cnt    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      ld_cnt    <= ld_cnt_next;
      wd_cnt    <= wd_cnt_next;
      timeout_q <= timeout_next;
    end
  end

  assign o_data_mux_alu_forward_src_a = i_rst ? 2'b00 : fwd_a;
  assign o_data_mux_alu_forward_src_b = i_rst ? 2'b00 : fwd_b;
  assign o_data_f_stall               = f_stall   & ~i_rst;
  assign o_data_fd_stall              = fd_stall  & ~i_rst;
  assign o_data_de_stall              = de_stall  & ~i_rst;
  assign o_de_flush                   = de_flush  & ~i_rst;
  assign o_data_fd_flush              = fd_flush  & ~i_rst;
  assign o_em_flush                   = em_flush  & ~i_rst;
  assign o_mdu_start                  = mdu_start & ~i_rst;
  assign o_mdu_timeout                = timeout_q & ~i_rst;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: directed vectors push their expected
// output word into a queue, a negedge monitor pops and compares.
module tb_hazard_unit_mc;

  // Stimulus vector applied for one clock cycle
  typedef struct packed {
    logic       rst;
    logic [4:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
    logic       use_rs1;
    logic [1:0] e_src, m_src;
    logic       m_we, w_we, pc_src, mdu_op, mdu_done;
  } stim_t;

  // Expected output word: {src_a, src_b, f, fd, de, de_flush, fd_flush, em_flush, start, timeout}
  typedef struct packed {
    logic [1:0] a, b;
    logic [7:0] flags;
  } exp_t;

  localparam logic [7:0] F_NONE  = 8'b0000_0000;
  localparam logic [7:0] F_LD    = 8'b1101_0000;
  localparam logic [7:0] F_BR    = 8'b0001_1000;
  localparam logic [7:0] F_START = 8'b1110_0110;
  localparam logic [7:0] F_BUSY  = 8'b1110_0100;
  localparam logic [7:0] F_BUSYT = 8'b1110_0101;
  localparam logic [7:0] F_TO    = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
  logic       use_rs1;
  logic [1:0] e_src, m_src;
  logic       m_we, w_we, pc_src, mdu_op, mdu_done;
  logic [1:0] src_a, src_b;
  logic       f_stall, fd_stall, de_stall, de_flush, fd_flush, em_flush;
  logic       mdu_start, mdu_timeout;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(
    .REG_ADDR_W        (5),
    .LOAD_STALL_CYCLES (3),
    .MDU_TIMEOUT       (4)
  ) dut (
    .i_clk                         (clk),
    .i_rst                         (rst),
    .i_data_d_rs1                  (d_rs1),
    .i_data_d_rs2                  (d_rs2),
    .i_data_e_rs1                  (e_rs1),
    .i_data_e_rs2                  (e_rs2),
    .i_data_e_rd                   (e_rd),
    .i_data_m_rd                   (m_rd),
    .i_data_w_rd                   (w_rd),
    .i_ctrl_d_use_rs1              (use_rs1),
    .i_ctrl_e_mux_final_result_src (e_src),
    .i_ctrl_m_mux_final_result_src (m_src),
    .i_ctrl_m_en_regfile_write     (m_we),
    .i_ctrl_w_en_regfile_write     (w_we),
    .i_ctrl_e_mux_pc_src           (pc_src),
    .i_ctrl_e_mdu_op               (mdu_op),
    .i_mdu_done                    (mdu_done),
    .o_data_mux_alu_forward_src_a  (src_a),
    .o_data_mux_alu_forward_src_b  (src_b),
    .o_data_f_stall                (f_stall),
    .o_data_fd_stall               (fd_stall),
    .o_data_de_stall               (de_stall),
    .o_de_flush                    (de_flush),
    .o_data_fd_flush               (fd_flush),
    .o_em_flush                    (em_flush),
    .o_mdu_start                   (mdu_start),
    .o_mdu_timeout                 (mdu_timeout)
  );

  function automatic stim_t base();
    stim_t s;
    s         = '0;
    s.use_rs1 = 1'b1;
    return s;
  endfunction

  function automatic exp_t mk(input logic [1:0] a, input logic [1:0] b, input logic [7:0] flags);
    exp_t e;
    e.a     = a;
    e.b     = b;
    e.flags = flags;
    return e;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the expectation
  task automatic applyStimulus(input string name, input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst      = s.rst;
    d_rs1    = s.d_rs1;
    d_rs2    = s.d_rs2;
    e_rs1    = s.e_rs1;
    e_rs2    = s.e_rs2;
    e_rd     = s.e_rd;
    m_rd     = s.m_rd;
    w_rd     = s.w_rd;
    use_rs1  = s.use_rs1;
    e_src    = s.e_src;
    m_src    = s.m_src;
    m_we     = s.m_we;
    w_we     = s.w_we;
    pc_src   = s.pc_src;
    mdu_op   = s.mdu_op;
    mdu_done = s.mdu_done;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Compare the DUT output word against one scoreboard entry
  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act = {src_a, src_b, f_stall, fd_stall, de_stall, de_flush, fd_flush,
           em_flush, mdu_start, mdu_timeout};
    tests_run++;
    if (act !== e) begin
      tests_failed++;
      $display("[TB] FAIL %s: got a=%b b=%b flags=%b, expected a=%b b=%b flags=%b (f,fd,de,deF,fdF,emF,start,to)",
               name, act.a, act.b, act.flags, e.a, e.b, e.flags);
    end
  endtask

  // Monitor: each falling edge retires one queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(name_q.pop_front(), exp_q.pop_front());
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1; d_rs1 = '0; d_rs2 = '0; e_rs1 = '0; e_rs2 = '0; e_rd = '0;
    m_rd = '0; w_rd = '0; use_rs1 = 1'b1; e_src = '0; m_src = '0;
    m_we = 1'b0; w_we = 1'b0; pc_src = 1'b0; mdu_op = 1'b0; mdu_done = 1'b0;

    // Reset masks a live forwarding match, then forwarding cases
    s = base(); s.rst = 1'b1; s.e_rs1 = 5'd5; s.m_rd = 5'd5; s.m_we = 1'b1; s.m_src = 2'b11;
    applyStimulus("reset_masks_fwd", s, mk(2'b00, 2'b00, F_NONE));
    applyStimulus("reset_masks_fwd2", s, mk(2'b00, 2'b00, F_NONE));
    s.rst = 1'b0;
    applyStimulus("fwd_m_pc4", s, mk(2'b11, 2'b00, F_NONE));
    s.m_src = 2'b00; s.e_rs2 = 5'd5;
    applyStimulus("fwd_m_alu", s, mk(2'b10, 2'b10, F_NONE));
    s.m_rd = 5'd0; s.w_rd = 5'd5; s.w_we = 1'b1;
    applyStimulus("fwd_w", s, mk(2'b01, 2'b01, F_NONE));
    s.m_rd = 5'd5; s.m_we = 1'b0;
    applyStimulus("fwd_m_we_low", s, mk(2'b01, 2'b01, F_NONE));
    s.m_we = 1'b1; s.m_src = 2'b01;
    applyStimulus("fwd_m_over_w", s, mk(2'b10, 2'b10, F_NONE));
    s.e_rs1 = 5'd0; s.e_rs2 = 5'd0; s.m_rd = 5'd0; s.w_rd = 5'd0;
    applyStimulus("fwd_x0", s, mk(2'b00, 2'b00, F_NONE));
    s = base(); s.e_rs1 = 5'd3; s.e_rs2 = 5'd9; s.w_rd = 5'd9; s.w_we = 1'b1;
    applyStimulus("fwd_b_only", s, mk(2'b00, 2'b01, F_NONE));

    // Load-use on rs2: exactly three stall cycles
    s = base(); s.e_src = 2'b01; s.e_rd = 5'd7; s.d_rs2 = 5'd7;
    applyStimulus("ld_detect", s, mk(2'b00, 2'b00, F_LD));
    applyStimulus("ld_stall2", s, mk(2'b00, 2'b00, F_LD));
    applyStimulus("ld_stall3", s, mk(2'b00, 2'b00, F_LD));
    s.e_src = 2'b00;
    applyStimulus("ld_release", s, mk(2'b00, 2'b00, F_NONE));

    // rs1 match only counts when rs1 is used; LD_STALL ignores inputs
    s = base(); s.e_src = 2'b01; s.e_rd = 5'd7; s.d_rs1 = 5'd7; s.use_rs1 = 1'b0; s.d_rs2 = 5'd3;
    applyStimulus("ld_rs1_unused", s, mk(2'b00, 2'b00, F_NONE));
    s.use_rs1 = 1'b1;
    applyStimulus("ld_rs1_used", s, mk(2'b00, 2'b00, F_LD));
    s = base();
    applyStimulus("ld_ignored_1", s, mk(2'b00, 2'b00, F_LD));
    applyStimulus("ld_ignored_2", s, mk(2'b00, 2'b00, F_LD));
    applyStimulus("ld_done_2", s, mk(2'b00, 2'b00, F_NONE));
    s = base(); s.e_src = 2'b01;
    applyStimulus("ld_rd_zero", s, mk(2'b00, 2'b00, F_NONE));

    // Branch flush, and branch taking priority over a load-use
    s = base(); s.pc_src = 1'b1;
    applyStimulus("br_flush", s, mk(2'b00, 2'b00, F_BR));
    s.pc_src = 1'b0;
    applyStimulus("br_clear", s, mk(2'b00, 2'b00, F_NONE));
    s = base(); s.pc_src = 1'b1; s.e_src = 2'b01; s.e_rd = 5'd7; s.d_rs2 = 5'd7;
    applyStimulus("br_over_ld", s, mk(2'b00, 2'b00, F_BR));
    s = base();
    applyStimulus("br_over_ld_idle", s, mk(2'b00, 2'b00, F_NONE));

    // MDU with three busy cycles, done on the fourth; watchdog stays low
    s = base(); s.mdu_op = 1'b1;
    applyStimulus("mdu_start", s, mk(2'b00, 2'b00, F_START));
    applyStimulus("mdu_busy1", s, mk(2'b00, 2'b00, F_BUSY));
    s.pc_src = 1'b1;
    applyStimulus("mdu_ignore_br", s, mk(2'b00, 2'b00, F_BUSY));
    s.pc_src = 1'b0; s.e_src = 2'b01; s.e_rd = 5'd7; s.d_rs2 = 5'd7;
    applyStimulus("mdu_ignore_ld", s, mk(2'b00, 2'b00, F_BUSY));
    s.e_src = 2'b00; s.mdu_done = 1'b1;
    applyStimulus("mdu_done", s, mk(2'b00, 2'b00, F_NONE));
    s = base();
    applyStimulus("mdu_after", s, mk(2'b00, 2'b00, F_NONE));

    // Watchdog: rises after the 4th busy cycle, sticky, cleared by reset
    s = base(); s.mdu_op = 1'b1;
    applyStimulus("wd_start", s, mk(2'b00, 2'b00, F_START));
    applyStimulus("wd_busy1", s, mk(2'b00, 2'b00, F_BUSY));
    applyStimulus("wd_busy2", s, mk(2'b00, 2'b00, F_BUSY));
    applyStimulus("wd_busy3", s, mk(2'b00, 2'b00, F_BUSY));
    applyStimulus("wd_busy4", s, mk(2'b00, 2'b00, F_BUSY));
    applyStimulus("wd_busy5_to", s, mk(2'b00, 2'b00, F_BUSYT));
    applyStimulus("wd_busy6_to", s, mk(2'b00, 2'b00, F_BUSYT));
    s.mdu_done = 1'b1;
    applyStimulus("wd_done_sticky", s, mk(2'b00, 2'b00, F_TO));
    s = base();
    applyStimulus("wd_idle_sticky", s, mk(2'b00, 2'b00, F_TO));
    s.mdu_op = 1'b1;
    applyStimulus("wd_restart", s, mk(2'b00, 2'b00, F_START | F_TO));
    s.rst = 1'b1;
    applyStimulus("rst_mid_mdu", s, mk(2'b00, 2'b00, F_NONE));
    applyStimulus("rst_hold", s, mk(2'b00, 2'b00, F_NONE));
    s = base();
    applyStimulus("rst_release", s, mk(2'b00, 2'b00, F_NONE));
    applyStimulus("rst_no_start", s, mk(2'b00, 2'b00, F_NONE));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
